// File: rtl/conv_mac_sequencer_pkg.sv
// conv_mac_sequencer shared package: fixed-point format defaults,
// width derivation, FSM state codes and saturation limits.
package conv_mac_sequencer_pkg;

  localparam int INT_BITS  = 2;
  localparam int FRAC_BITS = 14;
  localparam int TAPS_DEF  = 9;
  localparam int GUARD_DEF = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  function automatic int data_w(int i, int f);
    return i + f;
  endfunction

  function automatic int acc_w(int dw, int g);
    return dw + g;
  endfunction

  function automatic longint sat_max(int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/fxp_mul_reg.sv
// Registered signed fixed-point multiply: full product, arithmetic
// shift by the fraction width, low DW bits kept (wraps).
module fxp_mul_reg
  import conv_mac_sequencer_pkg::*;
#(
  parameter int DW   = data_w(INT_BITS, FRAC_BITS),
  parameter int FRAC = FRAC_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [DW-1:0] p,
  output logic                 pv
);

  logic signed [2*DW-1:0] full;

  assign full = a * b;

  always_ff @(posedge clk) begin
    if (reset) begin
      p  <= '0;
      pv <= 1'b0;
    end else begin
      pv <= en;
      if (en) p <= DW'(full >>> FRAC);
    end
  end

endmodule

// File: rtl/conv_mac_sequencer.sv
// Convolution-window MAC sequencer sharing one multiplier over N_TAPS.
// Define CONV_MAC_SATURATE_EN to clamp the result instead of wrapping.
module conv_mac_sequencer
  import conv_mac_sequencer_pkg::*;
#(
  parameter int INTEGER  = INT_BITS,
  parameter int FRACTION = FRAC_BITS,
  parameter int N_TAPS   = TAPS_DEF,
  parameter int GUARD    = GUARD_DEF,
  localparam int DW = data_w(INTEGER, FRACTION),
  localparam int AW = acc_w(DW, GUARD),
  localparam int CW = $clog2(N_TAPS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_pixel,
  input  logic [DW-1:0] s_weight,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          busy,
  output logic [CW-1:0] tap_count
);

  localparam logic [CW-1:0] LAST = CW'(N_TAPS - 1);

  logic [1:0]           state;
  logic                 beat;
  logic                 hs;
  logic                 pv;
  logic signed [DW-1:0] prod;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_nx;
  logic [DW-1:0]        out_nx;

  assign s_ready = (state == S_IDLE) || (state == S_ACCUM);
  assign m_valid = (state == S_DONE);
  assign busy    = (state != S_IDLE);
  assign beat    = s_valid && s_ready;
  assign hs      = m_valid && m_ready;

  fxp_mul_reg #(
    .DW   (DW),
    .FRAC (FRACTION)
  ) u_mul (
    .clk   (clk),
    .reset (reset),
    .en    (beat),
    .a     (s_pixel),
    .b     (s_weight),
    .p     (prod),
    .pv    (pv)
  );

  // Sum as it will be once the in-flight product lands
  assign acc_nx = pv ? acc + {{GUARD{prod[DW-1]}}, prod} : acc;

`ifdef CONV_MAC_SATURATE_EN
  localparam logic signed [AW-1:0] HI = AW'(sat_max(DW));
  localparam logic signed [AW-1:0] LO = AW'(sat_min(DW));

  always_comb begin
    out_nx = acc_nx[DW-1:0];
    if (acc_nx > HI)      out_nx = {1'b0, {(DW-1){1'b1}}};
    else if (acc_nx < LO) out_nx = {1'b1, {(DW-1){1'b0}}};
  end
`else
  assign out_nx = acc_nx[DW-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      tap_count <= '0;
      acc       <= '0;
      m_data    <= '0;
    end else begin
      acc <= hs ? '0 : acc_nx;
      unique case (state)
        S_IDLE: if (beat) begin
          tap_count <= CW'(1);
          state     <= (N_TAPS == 1) ? S_DRAIN : S_ACCUM;
        end
        S_ACCUM: if (beat) begin
          tap_count <= tap_count + CW'(1);
          if (tap_count == LAST) state <= S_DRAIN;
        end
        S_DRAIN: begin
          m_data <= out_nx;
          state  <= S_DONE;
        end
        S_DONE: if (m_ready) begin
          tap_count <= '0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Self-checking bench for conv_mac_sequencer: window-level model plus
// directed windows with hand-computed results.
module tb_conv_mac_sequencer;

  localparam int N = 9;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_pixel = '0;
  logic [15:0] s_weight = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_data;
  logic        busy;
  logic [3:0]  tap_count;

  int tests = 0;
  int fails = 0;

  conv_mac_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_pixel   (s_pixel),
    .s_weight  (s_weight),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .busy      (busy),
    .tap_count (tap_count)
  );

  always #5 clk = ~clk;

  function automatic longint mprod(logic [15:0] p, logic [15:0] w);
    longint f;
    logic [15:0] t;
    f = longint'($signed(p)) * longint'($signed(w));
    f = f >>> 14;
    t = f[15:0];
    return longint'($signed(t));
  endfunction

  function automatic logic [15:0] mout(longint s);
`ifdef CONV_MAC_SATURATE_EN
    if (s > 32767) return 16'h7fff;
    if (s < -32768) return 16'h8000;
`endif
    return s[15:0];
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Window model: taps and sum of accepted beats, cycle of last beat
  int     mtaps = 0;
  longint msum = 0;
  int     cyc = 0;
  int     last_cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      mtaps = 0;
      msum  = 0;
    end else begin
      if (s_valid && s_ready) begin
        msum += mprod(s_pixel, s_weight);
        mtaps++;
        last_cyc = cyc;
      end
      if (m_valid && m_ready) begin
        mtaps = 0;
        msum  = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("taps", 32'(tap_count), 32'(mtaps));
      chk("busy", 32'(busy), 32'(mtaps != 0));
      chk("s_ready", 32'(s_ready), 32'(mtaps < N));
      chk("m_valid", 32'(m_valid),
          32'(mtaps == N && (cyc - last_cyc) >= 1));
      if (m_valid) chk("m_data", 32'(m_data), 32'(mout(msum)));
    end
  end

  task automatic send(logic [15:0] px, logic [15:0] wt, int bub);
    repeat (bub) @(negedge clk);
    s_valid  = 1'b1;
    s_pixel  = px;
    s_weight = wt;
    @(negedge clk);
    s_valid  = 1'b0;
  endtask

  task automatic feed(logic [15:0] p1, logic [15:0] w1, int n1,
                      logic [15:0] p2, logic [15:0] w2, int n2,
                      bit bubbles);
    for (int i = 0; i < n1 + n2; i++) begin
      int b;
      b = bubbles ? int'($urandom_range(1, 3)) : 0;
      if (i < n1) send(p1, w1, b);
      else        send(p2, w2, b);
    end
  endtask

  task automatic finish_win(string nm, logic [15:0] exp, int hold);
    chk({nm, "_lat1"}, 32'(m_valid), 32'd0);
    @(negedge clk);
    chk({nm, "_lat2"}, 32'(m_valid), 32'd1);
    chk({nm, "_data"}, 32'(m_data), 32'(exp));
    repeat (hold) @(negedge clk);
    if (hold > 0) begin
      chk({nm, "_hold_v"}, 32'(m_valid), 32'd1);
      chk({nm, "_hold_r"}, 32'(s_ready), 32'd0);
      chk({nm, "_hold_d"}, 32'(m_data), 32'(exp));
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk({nm, "_clr"}, 32'(m_valid), 32'd0);
    chk({nm, "_taps0"}, 32'(tap_count), 32'd0);
  endtask

  logic [15:0] big_pos;
  logic [15:0] big_neg;

  initial begin
`ifdef CONV_MAC_SATURATE_EN
    big_pos = 16'h7fff;
    big_neg = 16'h8000;
`else
    big_pos = 16'h4000;
    big_neg = 16'hc000;
`endif
    chk("pin_q", 32'(mprod(16'h1000, 16'h2000)), 32'h800);
    chk("pin_n", 32'(mprod(16'h4000, 16'hc000)), 32'hffffc000);
    chk("pin_1", 32'(mout(9 * mprod(16'h1000, 16'h2000))), 32'h4800);
    chk("pin_3", 32'(mout(9 * mprod(16'h4000, 16'h4000))), 32'(big_pos));

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_mv", 32'(m_valid), 32'd0);
    chk("rst_md", 32'(m_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_taps", 32'(tap_count), 32'd0);
    chk("rst_rdy", 32'(s_ready), 32'd1);

    feed(16'h1000, 16'h2000, 9, 16'h0, 16'h0, 0, 1'b0);
    finish_win("c1", 16'h4800, 0);

    feed(16'h4000, 16'hc000, 4, 16'h4000, 16'h4000, 5, 1'b0);
    finish_win("c2", 16'h4000, 0);

    feed(16'h4000, 16'h4000, 9, 16'h0, 16'h0, 0, 1'b0);
    finish_win("c3p", big_pos, 0);
    feed(16'h4000, 16'hc000, 9, 16'h0, 16'h0, 0, 1'b0);
    finish_win("c3n", big_neg, 0);

    feed(16'h1000, 16'h2000, 9, 16'h0, 16'h0, 0, 1'b0);
    finish_win("c4a", 16'h4800, 5);
    feed(16'h1000, 16'h2000, 9, 16'h0, 16'h0, 0, 1'b0);
    finish_win("c4b", 16'h4800, 0);

    feed(16'h4000, 16'h4000, 4, 16'h0, 16'h0, 0, 1'b0);
    chk("c5_taps4", 32'(tap_count), 32'd4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("c5_mv", 32'(m_valid), 32'd0);
    chk("c5_busy", 32'(busy), 32'd0);
    chk("c5_taps", 32'(tap_count), 32'd0);
    chk("c5_rdy", 32'(s_ready), 32'd1);
    feed(16'h4000, 16'hc000, 4, 16'h4000, 16'h4000, 5, 1'b0);
    finish_win("c5", 16'h4000, 0);

    feed(16'h1000, 16'h2000, 9, 16'h0, 16'h0, 0, 1'b1);
    finish_win("c6", 16'h4800, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
